// File: rtl/bpsk_frame_serializer.sv
// BPSK frame serializer: turns a byte stream into preamble + payload + guard
// symbol samples, one sample per PERIOD clocks, with a strobe for each new sample.
module bpsk_frame_serializer #(
  parameter int         WIDTH     = 4,
  parameter int         PERIOD    = 8,
  parameter int         AMPLITUDE = 7,
  parameter logic [7:0] PREAMBLE  = 8'hA5,
  parameter int         GUARD     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] sym_out,
  output logic                    sym_strobe,
  output logic                    busy,
  output logic                    underrun
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);
  localparam logic [3:0] GUARD_LAST = 4'(GUARD - 1);
  localparam logic signed [WIDTH-1:0] AMP_POS = WIDTH'(AMPLITUDE);
  localparam logic signed [WIDTH-1:0] AMP_NEG = WIDTH'(-AMPLITUDE);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_GUARD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [3:0]    guard_cnt;
  logic [7:0]    hold_data;
  logic          hold_last;
  logic          hold_full;
  logic [7:0]    shifter;
  logic          cur_last;
  logic          ready_en;
  logic          take;
  logic          wrap;
  logic          byte_end;

  assign take       = in_valid && in_ready;
  assign wrap       = (cnt == CNT_MAX);
  assign byte_end   = wrap && (bit_cnt == 3'd7);
  // ready_en keeps in_ready low until the first clock after reset release
  assign in_ready   = ready_en && !hold_full && (state != S_GUARD);
  assign busy       = (state != S_IDLE);
  assign sym_strobe = busy && (cnt == '0);
  // the decision uses registered hold_full, so a byte arriving in this cycle is late
  assign underrun   = (state == S_PAYLOAD) && byte_end && !cur_last && !hold_full;

  function automatic logic signed [WIDTH-1:0] bit_sym(input logic b);
    return b ? AMP_POS : AMP_NEG;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= 3'd0;
      guard_cnt <= 4'd0;
      hold_data <= 8'd0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      shifter   <= 8'd0;
      cur_last  <= 1'b0;
      ready_en  <= 1'b0;
      sym_out   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (take) begin
        hold_data <= in_data;
        hold_last <= in_last;
        hold_full <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          cnt <= '0;
          // a byte left in hold by a late arrival starts the next frame too
          if (take || hold_full) begin
            state   <= S_PREAMBLE;
            bit_cnt <= 3'd0;
            sym_out <= bit_sym(PREAMBLE[7]);
          end
        end
        S_PREAMBLE: begin
          if (!wrap) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state     <= S_PAYLOAD;
              bit_cnt   <= 3'd0;
              shifter   <= hold_data;
              cur_last  <= hold_last;
              hold_full <= 1'b0;
              sym_out   <= bit_sym(hold_data[7]);
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              sym_out <= bit_sym(PREAMBLE[3'd6 - bit_cnt]);
            end
          end
        end
        S_PAYLOAD: begin
          if (!wrap) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (bit_cnt == 3'd7) begin
              if (cur_last || !hold_full) begin
                state     <= S_GUARD;
                guard_cnt <= 4'd0;
                sym_out   <= '0;
              end else begin
                bit_cnt   <= 3'd0;
                shifter   <= hold_data;
                cur_last  <= hold_last;
                hold_full <= 1'b0;
                sym_out   <= bit_sym(hold_data[7]);
              end
            end else begin
              // rotate so the next bit to send sits in bit 7
              bit_cnt <= bit_cnt + 3'd1;
              shifter <= {shifter[6:0], shifter[7]};
              sym_out <= bit_sym(shifter[6]);
            end
          end
        end
        S_GUARD: begin
          if ((cnt == '0) && (guard_cnt == GUARD_LAST)) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (wrap) begin
            cnt       <= '0;
            guard_cnt <= guard_cnt + 4'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_frame_serializer.sv
// Directed bench for bpsk_frame_serializer with PERIOD=4: checks symbol streams,
// strobe timing, underrun, late byte, mid-frame reset and backpressure.
module tb_bpsk_frame_serializer;

  localparam int WIDTH = 4;
  localparam int PERIOD = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] sym_out;
  logic             sym_strobe;
  logic             busy;
  logic             underrun;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0;
  int idle_cyc;
  int n;

  logic [3:0] samp[$];
  int         scyc[$];
  int         xq[$];
  int         ur_cyc[$];
  logic [3:0] expq[$];

  bpsk_frame_serializer #(
    .WIDTH(WIDTH), .PERIOD(PERIOD), .AMPLITUDE(7), .PREAMBLE(8'hA5), .GUARD(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .sym_out(sym_out),
    .sym_strobe(sym_strobe), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // cyc counts posedges; a transfer at an edge is logged with the cycle it opens
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) begin
      xq.push_back(cyc + 1);
      $display("xfer cycle=%0d data=%h last=%b", cyc + 1, in_data, in_last);
    end
  end

  always @(negedge clk) begin
    if (sym_strobe) begin
      samp.push_back(sym_out);
      scyc.push_back(cyc);
    end
    if (underrun) ur_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    samp.delete(); scyc.delete(); xq.delete(); ur_cyc.delete(); expq.delete();
  endtask

  task automatic exp_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) expq.push_back(b[i] ? 4'h7 : 4'h9);
  endtask

  task automatic exp_zero(input int k);
    repeat (k) expq.push_back(4'h0);
  endtask

  task automatic cmp_stream(input string tag);
    check({tag, "_count"}, samp.size(), expq.size());
    for (int i = 0; i < expq.size() && i < samp.size(); i++)
      check($sformatf("%s_sym%0d", tag, i), samp[i], expq[i]);
  endtask

  // offered from IDLE, where in_ready is already high
  task automatic send(input logic [7:0] b, input logic l);
    @(negedge clk);
    in_data = b; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    idle_cyc = cyc;
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_sym_out", sym_out, 4'h0);
    check("rst_strobe", sym_strobe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_in_ready_before_clk", in_ready, 1'b0);
    @(negedge clk);
    check("rel_in_ready_after_clk", in_ready, 1'b1);

    // single byte 0x80, last
    clear_log();
    send(8'h80, 1'b1);
    wait_idle("t1", 200);
    exp_byte(8'hA5); exp_byte(8'h80); exp_zero(2);
    cmp_stream("t1");
    check("t1_xfers", xq.size(), 1);
    check("t1_first_strobe", scyc[0], xq[0]);
    check("t1_strobe_span", scyc[17] - scyc[0], 17 * PERIOD);
    check("t1_busy_fall", idle_cyc, scyc[17] + 1);
    check("t1_underruns", ur_cyc.size(), 0);

    // two-byte frame, second byte waiting during the preamble
    clear_log();
    send(8'hFF, 1'b0);
    t0 = xq[0];
    check("t2_ready_low_after_byte1", in_ready, 1'b0);
    in_data = 8'h00; in_last = 1'b1; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t2_ready_rise", cyc, t0 + 8 * PERIOD);
    check("t2_rise_is_strobe", sym_strobe, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("t2_ready_low_after_byte2", in_ready, 1'b0);
    check("t2_byte2_cycle", xq.size() > 1 ? xq[1] : -1, t0 + 8 * PERIOD + 1);
    wait_idle("t2", 300);
    exp_byte(8'hA5); exp_byte(8'hFF); exp_byte(8'h00); exp_zero(2);
    cmp_stream("t2");
    check("t2_underruns", ur_cyc.size(), 0);

    // underrun after one non-last byte
    clear_log();
    send(8'h55, 1'b0);
    t0 = xq[0];
    wait_idle("t3", 300);
    exp_byte(8'hA5); exp_byte(8'h55); exp_zero(2);
    cmp_stream("t3");
    check("t3_underruns", ur_cyc.size(), 1);
    check("t3_underrun_cycle", ur_cyc.size() > 0 ? ur_cyc[0] : -1, t0 + 16 * PERIOD - 1);
    check("t3_first_guard", scyc.size() > 16 ? scyc[16] : -1, t0 + 16 * PERIOD);
    check("t3_busy_fall", idle_cyc, t0 + 17 * PERIOD + 1);

    // late byte offered in the decision cycle
    clear_log();
    send(8'h0F, 1'b0);
    t0 = xq[0];
    wait_cyc(t0 + 16 * PERIOD - 1);
    check("t4_underrun_at_decision", underrun, 1'b1);
    check("t4_ready_at_decision", in_ready, 1'b1);
    in_data = 8'hF0; in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_late_xfers", xq.size(), 2);
    check("t4_late_cycle", xq.size() > 1 ? xq[1] : -1, t0 + 16 * PERIOD);
    wait_cyc(t0 + 36 * PERIOD + 10);
    check("t4_idle", busy, 1'b0);
    exp_byte(8'hA5); exp_byte(8'h0F); exp_zero(2);
    exp_byte(8'hA5); exp_byte(8'hF0); exp_zero(2);
    cmp_stream("t4");
    check("t4_underruns", ur_cyc.size(), 1);
    check("t4_frame2_start", scyc.size() > 18 ? scyc[18] : -1, t0 + 17 * PERIOD + 2);

    // reset at the third payload strobe
    clear_log();
    send(8'h3C, 1'b1);
    t0 = xq[0];
    wait_cyc(t0 + 10 * PERIOD);
    check("t5_third_payload_strobe", sym_strobe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t5_sym_out", sym_out, 4'h0);
    check("t5_strobe", sym_strobe, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_in_ready", in_ready, 1'b0);
    check("t5_underrun", underrun, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("t5_ready_before_clk", in_ready, 1'b0);
    @(negedge clk);
    check("t5_ready_after_clk", in_ready, 1'b1);
    samp.delete();
    repeat (60) @(negedge clk);
    check("t5_no_strobes", samp.size(), 0);
    check("t5_idle", busy, 1'b0);

    // backpressure: in_valid held through guard
    clear_log();
    send(8'hC3, 1'b1);
    t0 = xq[0];
    wait_cyc(t0 + 16 * PERIOD);
    check("t6_guard_strobe", sym_strobe, 1'b1);
    check("t6_guard_zero", sym_out, 4'h0);
    in_data = 8'h5A; in_last = 1'b1; in_valid = 1'b1;
    while (cyc < t0 + 17 * PERIOD + 1) begin
      check($sformatf("t6_guard_ready_c%0d", cyc - t0), in_ready, 1'b0);
      @(negedge clk);
    end
    check("t6_idle_busy", busy, 1'b0);
    check("t6_idle_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    check("t6_xfers", xq.size(), 2);
    check("t6_take_cycle", xq.size() > 1 ? xq[1] : -1, t0 + 17 * PERIOD + 2);
    wait_idle("t6", 300);
    exp_byte(8'hA5); exp_byte(8'hC3); exp_zero(2);
    exp_byte(8'hA5); exp_byte(8'h5A); exp_zero(2);
    cmp_stream("t6");
    check("t6_frame2_start", scyc.size() > 18 ? scyc[18] : -1, t0 + 17 * PERIOD + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
